// File: rtl/pe_shift_accum.sv
// pe_shift_accum: bit-serial MSB-first shift-accumulate over LANES lanes; define PE_SACC_SAT_EN for saturating arithmetic with sticky ovf
module pe_shift_accum #(
    parameter int LANES   = 4,
    parameter int INWD    = 16,
    parameter int PSUMDWD = 32,
    parameter int MAXBITS = 8,
    localparam int CW     = $clog2(MAXBITS + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [CW-1:0]              cfg_wb,
    input  logic                       cfg_signed,
    input  logic [1:0]                 cfg_sht,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*INWD-1:0]      in_data,
    input  logic                       in_fstpix,
    input  logic                       in_lstpix,
    input  logic [LANES*PSUMDWD-1:0]   psum_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*PSUMDWD-1:0]   out_data,
    output logic                       out_last,
    output logic                       ovf
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [PSUMDWD-1:0] SMAX = {1'b0, {(PSUMDWD-1){1'b1}}};
    localparam logic [PSUMDWD-1:0] SMIN = {1'b1, {(PSUMDWD-1){1'b0}}};

    // Result MSB carries the saturation flag, low bits the value.
    function automatic logic [PSUMDWD:0] shl(input logic [PSUMDWD-1:0] a, input logic [1:0] sh);
`ifdef PE_SACC_SAT_EN
        logic [PSUMDWD-1:0] t;
        t = PSUMDWD'($signed(a) >>> (PSUMDWD - 1 - (1 << sh)));
        if (t != '0 && t != '1) return {1'b1, a[PSUMDWD-1] ? SMIN : SMAX};
`endif
        return {1'b0, a << (1 << sh)};
    endfunction

    function automatic logic [PSUMDWD:0] add(input logic [PSUMDWD-1:0] a, input logic [PSUMDWD-1:0] b);
        logic [PSUMDWD-1:0] s;
        s = a + b;
`ifdef PE_SACC_SAT_EN
        if (a[PSUMDWD-1] == b[PSUMDWD-1] && s[PSUMDWD-1] != a[PSUMDWD-1])
            return {1'b1, a[PSUMDWD-1] ? SMIN : SMAX};
`endif
        return {1'b0, s};
    endfunction

    state_t                   st_q, st_d;
    logic [CW-1:0]            cnt_q, cnt_d, wb_q, wb_d;
    logic                     sgn_q, sgn_d;
    logic [1:0]               sht_q, sht_d;
    logic [PSUMDWD-1:0]       acc_q [LANES];
    logic [PSUMDWD-1:0]       acc_d [LANES];
    logic [PSUMDWD-1:0]       base_q [LANES];
    logic [PSUMDWD-1:0]       base_d [LANES];
    logic                     last_q, last_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_last_q, out_last_d;
    logic                     ovf_q, ovf_d;
    logic [LANES*PSUMDWD-1:0] out_data_q, out_data_d;
    logic                     cfg_fire, in_fire, first, lst;
    logic [PSUMDWD-1:0]       p, a, b;
    logic [PSUMDWD:0]         sr, sm, fin;

    assign cfg_ready = (cnt_q == '0) && !out_valid_q;
    assign in_ready  = (st_q == RUN) && (!out_valid_q || out_ready || cnt_q != '0)
                     && !(cnt_q == wb_q - CW'(1) && out_valid_q && !out_ready);
    assign cfg_fire  = cfg_valid && cfg_ready && cfg_wb != '0;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign ovf       = ovf_q;

    // A config loaded in the same cycle as a first plane already governs that plane.
    always_comb begin
        st_d        = cfg_fire ? RUN : st_q;
        wb_d        = cfg_fire ? cfg_wb : wb_q;
        sgn_d       = cfg_fire ? cfg_signed : sgn_q;
        sht_d       = cfg_fire ? cfg_sht : sht_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        base_d      = base_q;
        last_d      = last_q;
        out_valid_d = out_valid_q && !out_ready;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        ovf_d       = ovf_q;
        first       = cnt_q == '0;
        lst         = cnt_q == wb_d - CW'(1);
        p           = '0;
        a           = '0;
        b           = '0;
        sr          = '0;
        sm          = '0;
        fin         = '0;
        if (in_fire) begin
            for (int i = 0; i < LANES; i++) begin
                p  = PSUMDWD'($signed(in_data[i*INWD +: INWD]));
                sr = shl(acc_q[i], sht_d);
                sm = add(sr[PSUMDWD-1:0], p);
                a  = first ? (sgn_d ? -p : p) : sm[PSUMDWD-1:0];
                b  = first ? (in_fstpix ? '0 : psum_in[i*PSUMDWD +: PSUMDWD]) : base_q[i];
                fin = add(b, a);
                acc_d[i]  = a;
                base_d[i] = b;
                if (lst) out_data_d[i*PSUMDWD +: PSUMDWD] = fin[PSUMDWD-1:0];
                ovf_d = ovf_d || (!first && (sr[PSUMDWD] || sm[PSUMDWD])) || (lst && fin[PSUMDWD]);
            end
            last_d = first ? in_lstpix : last_q;
            cnt_d  = lst ? '0 : cnt_q + CW'(1);
            if (lst) begin
                out_valid_d = 1'b1;
                out_last_d  = first ? in_lstpix : last_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= IDLE;
            cnt_q       <= '0;
            wb_q        <= '0;
            sgn_q       <= 1'b0;
            sht_q       <= '0;
            acc_q       <= '{default: '0};
            base_q      <= '{default: '0};
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            wb_q        <= wb_d;
            sgn_q       <= sgn_d;
            sht_q       <= sht_d;
            acc_q       <= acc_d;
            base_q      <= base_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            ovf_q       <= ovf_d;
        end
    end
endmodule

// File: tb/tb_pe_shift_accum.sv
// tb_pe_shift_accum: directed scoreboard bench for pe_shift_accum with LANES=1
module tb_pe_shift_accum;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0, cfg_ready, cfg_signed = 1'b0;
    logic [3:0]  cfg_wb = '0;
    logic [1:0]  cfg_sht = '0;
    logic        in_valid = 1'b0, in_ready, in_fstpix = 1'b0, in_lstpix = 1'b0;
    logic [15:0] in_data = '0;
    logic [31:0] psum_in = '0, out_data;
    logic        out_valid, out_ready = 1'b1, out_last, ovf;
    int          n_cmp = 0, n_bad = 0;
    logic [32:0] sb [$];
    logic [32:0] exp_v;
    logic [31:0] held;
    logic        held_v = 1'b0;

    always #5 clk = ~clk;

    pe_shift_accum #(.LANES(1), .INWD(16), .PSUMDWD(32), .MAXBITS(8)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_wb(cfg_wb),
        .cfg_signed(cfg_signed), .cfg_sht(cfg_sht), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_fstpix(in_fstpix), .in_lstpix(in_lstpix), .psum_in(psum_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .ovf(ovf)
    );

    initial forever begin
        @(negedge clk);
        if (!rst && out_valid) begin
            if (held_v) begin
                n_cmp++;
                assert (out_data === held) else begin n_bad++; $error("FAIL hold: out_data=%h expected %h", out_data, held); end
            end
            if (out_ready) begin
                held_v = 1'b0;
                n_cmp++;
                assert (sb.size() != 0) else begin n_bad++; $error("FAIL unexpected_out: out_data=%h expected no result", out_data); end
                if (sb.size() != 0) begin
                    exp_v = sb.pop_front();
                    n_cmp++;
                    assert ({out_last, out_data} === exp_v) else begin
                        n_bad++; $error("FAIL result: last/data=%b/%h expected %b/%h", out_last, out_data, exp_v[32], exp_v[31:0]);
                    end
                end
            end else begin
                held_v = 1'b1;
                held   = out_data;
            end
        end else held_v = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin n_bad++; $error("FAIL %s: got %h expected %h", tag, got, want); end
    endtask

    task automatic do_cfg(input logic [3:0] wb, input logic sg, input logic [1:0] sh);
        int n = 0;
        cfg_valid = 1'b1; cfg_wb = wb; cfg_signed = sg; cfg_sht = sh;
        @(negedge clk);
        while (!cfg_ready && n < 50) begin @(negedge clk); n++; end
        chk("cfg_wait", 32'(cfg_ready), 32'd1);
        @(posedge clk); #1 cfg_valid = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input logic fst, input logic lst, input logic [31:0] ps, output int waits);
        in_valid = 1'b1; in_data = d; in_fstpix = fst; in_lstpix = lst; psum_in = ps; waits = 0;
        @(negedge clk);
        while (!in_ready && waits < 50) begin @(negedge clk); waits++; end
        chk("plane_wait", 32'(in_ready), 32'd1);
        @(posedge clk); #1 in_valid = 1'b0;
    endtask

    task automatic group(input int wb, input logic [15:0] pl [8], input logic fst, input logic lst,
                         input logic [31:0] ps, input logic [31:0] want, output int w);
        int wt;
        sb.push_back({lst, want});
        w = 0;
        for (int k = 0; k < wb; k++) begin send(pl[k], fst, lst, ps, wt); w += wt; end
    endtask

    function automatic logic [31:0] model(input logic [31:0] base, input logic [15:0] pl [8], input int wb, input int sh, input logic sg);
        longint v = 0;
        for (int k = 0; k < wb; k++) begin
            longint t;
            t = longint'($signed(pl[k])) <<< ((1 << sh) * (wb - 1 - k));
            v += (k == 0 && sg) ? -t : t;
        end
        return 32'(longint'($signed(base)) + v);
    endfunction

    initial begin
        logic [15:0] pl [8];
        logic [31:0] ps;
        int w, w2, n;
        int cfgs [4][3] = '{'{3, 1, 2}, '{8, 0, 0}, '{2, 1, 3}, '{8, 1, 0}};
        @(posedge clk); #1;
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        cfg_valid = 1'b1; cfg_wb = 4'd0;
        @(posedge clk); #1 cfg_valid = 1'b0;
        chk("wb0_in_ready", 32'(in_ready), 32'd0);
        chk("wb0_cfg_ready", 32'(cfg_ready), 32'd1);
        do_cfg(4, 1'b0, 2'd0);
        pl = '{16'd1, 16'd0, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0};
        group(4, pl, 1'b1, 1'b0, 32'd0, 32'd11, w);
        chk("unsigned_latency", 32'(out_valid), 32'd1);
        chk("unsigned_data", out_data, 32'd11);
        chk("unsigned_waits", 32'(w), 32'd0);
        @(posedge clk); #1;
        chk("valid_drop", 32'(out_valid), 32'd0);
        do_cfg(4, 1'b1, 2'd0);
        group(4, pl, 1'b1, 1'b0, 32'd0, 32'hFFFF_FFFB, w);
        chk("signed_data", out_data, 32'hFFFF_FFFB);
        do_cfg(2, 1'b0, 2'd1);
        pl = '{16'd3, 16'd2, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        group(2, pl, 1'b0, 1'b1, 32'd100, 32'd114, w);
        chk("seed_data", out_data, 32'd114);
        chk("seed_last", 32'(out_last), 32'd1);
        do_cfg(4, 1'b0, 2'd0);
        pl = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0};
        group(4, pl, 1'b1, 1'b0, 32'd0, model(32'd0, pl, 4, 0, 1'b0), w);
        pl = '{16'hFFFF, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0};
        group(4, pl, 1'b0, 1'b1, 32'd1000, model(32'd1000, pl, 4, 0, 1'b0), w2);
        chk("b2b_waits", 32'(w + w2), 32'd0);
        do_cfg(1, 1'b0, 2'd0);
        pl = '{16'd5, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        group(1, pl, 1'b1, 1'b0, 32'd0, 32'd5, w);
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'd7; in_fstpix = 1'b1; in_lstpix = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_data", out_data, 32'd5);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        pl[0] = 16'd7;
        group(1, pl, 1'b1, 1'b1, 32'd0, 32'd7, w);
        chk("stall_next_data", out_data, 32'd7);
        pl[0] = 16'h0020;
`ifdef PE_SACC_SAT_EN
        group(1, pl, 1'b0, 1'b0, 32'h7FFF_FFF0, 32'h7FFF_FFFF, w);
        chk("sat_ovf", 32'(ovf), 32'd1);
`else
        group(1, pl, 1'b0, 1'b0, 32'h7FFF_FFF0, 32'h8000_0010, w);
        chk("wrap_ovf", 32'(ovf), 32'd0);
`endif
        for (int g = 0; g < 4; g++) begin
            do_cfg(4'(cfgs[g][0]), cfgs[g][1] != 0, 2'(cfgs[g][2]));
            for (int k = 0; k < 8; k++) begin
                int r;
                r = int'($urandom_range(0, 255)) - 128;
                pl[k] = 16'(r);
            end
            ps = 32'($urandom_range(0, 100000));
            group(cfgs[g][0], pl, g[0], g[1], ps, model(g[0] ? 32'd0 : ps, pl, cfgs[g][0], cfgs[g][2], cfgs[g][1] != 0), w);
        end
        do_cfg(4, 1'b0, 2'd0);
        send(16'd9, 1'b1, 1'b0, 32'd0, w);
        send(16'd9, 1'b1, 1'b0, 32'd0, w);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("rstmid_out_valid", 32'(out_valid), 32'd0);
        chk("rstmid_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("rstmid_in_ready", 32'(in_ready), 32'd0);
        chk("rstmid_ovf", 32'(ovf), 32'd0);
        do_cfg(4, 1'b0, 2'd0);
        pl = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0};
        group(4, pl, 1'b1, 1'b0, 32'd0, 32'd15, w);
        n = 0;
        while (sb.size() != 0 && n < 20) begin @(posedge clk); n++; end
        #1 chk("drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
